// File: rtl/systolic_row_drain.sv
// Row drain unit: captures one row of N_COLS PE result bytes and streams them out in column order.
// Optional macro ROW_DRAIN_BACK2BACK_EN lets a new row load on the final-byte handshake edge without a bubble.
module systolic_row_drain #(
    parameter int DATA_W = 8,
    parameter int N_COLS = 4,
    parameter int IDX_W  = $clog2(N_COLS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [N_COLS*DATA_W-1:0] row_in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic                     load_err
);

    // Stream handshake: a byte transfers on a rising edge where out_valid and out_ready are both 1;
    // out_valid never drops without that transfer of the last byte, and all outputs hold while out_ready=0.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q [N_COLS];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                load_err_q, load_err_d;
    logic                capture;
    logic                at_last;
    logic                hs;
    logic                last_hs;

    assign at_last = (idx_q == IDX_W'(N_COLS - 1));
    assign hs      = (state_q == ST_DRAIN) && out_ready;
    assign last_hs = hs && at_last;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            load_err_q <= 1'b0;
            for (int k = 0; k < N_COLS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_err_q <= load_err_d;
            if (capture) begin
                for (int k = 0; k < N_COLS; k++) begin
                    buf_q[k] <= row_in[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        capture    = 1'b0;
        load_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_hs) begin
                    idx_d = '0;
`ifdef ROW_DRAIN_BACK2BACK_EN
                    if (load) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d    = ST_IDLE;
                    load_err_d = load;
`endif
                end else begin
                    if (hs) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    load_err_d = load;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q == ST_DRAIN);
        out_data  = '0;
        out_last  = 1'b0;
        out_index = '0;
        load_err  = load_err_q;
        if (state_q == ST_DRAIN) begin
            out_data  = buf_q[idx_q];
            out_last  = at_last;
            out_index = idx_q;
        end
    end

endmodule

// File: tb/tb_systolic_row_drain.sv
// Directed bench for systolic_row_drain: cycle-vector table plus hand-written corner sequences.
module tb_systolic_row_drain;

    localparam int DATA_W = 8;
    localparam int N_COLS = 4;
    localparam int IDX_W  = 2;

    logic                     clk;
    logic                     reset;
    logic                     load;
    logic [N_COLS*DATA_W-1:0] row_in;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic [IDX_W-1:0]         out_index;
    logic                     busy;
    logic                     load_err;

    int n_cmp;
    int n_err;

    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic        load;
        logic        ready;
        logic [31:0] row;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ei;
        logic        el;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    systolic_row_drain #(
        .DATA_W(DATA_W),
        .N_COLS(N_COLS),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .row_in   (row_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .out_index(out_index),
        .busy     (busy),
        .load_err (load_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [7:0] ed,
                              input logic [1:0] ei, input logic el, input logic ee);
        check({tag, " valid"}, 32'(out_valid), 32'(ev));
        check({tag, " busy"},  32'(busy),      32'(ev));
        check({tag, " data"},  32'(out_data),  32'(ed));
        check({tag, " index"}, 32'(out_index), 32'(ei));
        check({tag, " last"},  32'(out_last),  32'(el));
        check({tag, " err"},   32'(load_err),  32'(ee));
    endtask

    localparam logic [31:0] ROW_A = 32'hDDCCBBAA;
    localparam logic [31:0] ROW_B = 32'h11223344;

    initial begin
        logic hs;
        logic [7:0] exp_b;
        logic [31:0] cap_row;

        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        load      = 1'b0;
        out_ready = 1'b0;
        row_in    = '0;

        // Basic drain
        vecs.push_back(vec_t'{1'b1, 1'b1, ROW_A, 1'b1, 8'hAA, 2'd0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hCC, 2'd2, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hDD, 2'd3, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        // Backpressure on column 1
        vecs.push_back(vec_t'{1'b1, 1'b1, ROW_A, 1'b1, 8'hAA, 2'd0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hCC, 2'd2, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hDD, 2'd3, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        // Rejected load at index 1
        vecs.push_back(vec_t'{1'b1, 1'b1, ROW_A, 1'b1, 8'hAA, 2'd0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_A, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, ROW_B, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_B, 1'b1, 8'hCC, 2'd2, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_B, 1'b1, 8'hDD, 2'd3, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, ROW_B, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        // Row_in changes after capture
        vecs.push_back(vec_t'{1'b1, 1'b1, ROW_A,        1'b1, 8'hAA, 2'd0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h12345678, 1'b1, 8'hCC, 2'd2, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h00000000, 1'b1, 8'hDD, 2'd3, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h9ABCDEF0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_outs("post_reset_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            load      = vecs[i].load;
            out_ready = vecs[i].ready;
            row_in    = vecs[i].row;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ei, vecs[i].el, vecs[i].ee);
        end
        load = 1'b0;

        // Load on the last-byte handshake edge
        row_in    = ROW_A;
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        check_outs("b2b_at_last", 1'b1, 8'hDD, 2'd3, 1'b1, 1'b0);
        load   = 1'b1;
        row_in = ROW_B;
        tick();
        load = 1'b0;
`ifdef ROW_DRAIN_BACK2BACK_EN
        check_outs("b2b_col0", 1'b1, 8'h44, 2'd0, 1'b0, 1'b0);
        tick();
        check_outs("b2b_col1", 1'b1, 8'h33, 2'd1, 1'b0, 1'b0);
        tick();
        check_outs("b2b_col2", 1'b1, 8'h22, 2'd2, 1'b0, 1'b0);
        tick();
        check_outs("b2b_col3", 1'b1, 8'h11, 2'd3, 1'b1, 1'b0);
        tick();
        check_outs("b2b_done", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
`else
        check_outs("b2b_reject", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        tick();
        check_outs("b2b_err_clear", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
`endif

        // Reset mid-drain at index 2
        row_in = ROW_A;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (2) tick();
        check_outs("pre_reset_idx2", 1'b1, 8'hCC, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_outs($sformatf("after_reset%0d", c), 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        end

        // Scoreboard drain with stalls and a row_in that changes every cycle
        cap_row   = 32'h5A6B7C8D;
        row_in    = cap_row;
        load      = 1'b1;
        out_ready = 1'b0;
        tick();
        load = 1'b0;
        for (int k = 0; k < N_COLS; k++) begin
            exp_q.push_back(cap_row[k*DATA_W +: DATA_W]);
        end
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 3) != 1;
            row_in    = $urandom;
            hs        = out_valid && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_byte", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(exp_b));
                    check("sb_index", 32'(out_index), 32'(3 - exp_q.size()));
                    check("sb_last", 32'(out_last), 32'(exp_q.size() == 0));
                end
            end
            tick();
        end
        check("sb_remaining", 32'(exp_q.size()), 32'd0);
        check("sb_idle_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
